// File: rtl/pi1_arbiter_if.sv
// pi1 bus bundle between MASTERCOUNT masters, the arbiter and one shared slave.
// The slave modport is the arbiter's view; the master modport is its environment.
interface pi1_arbiter_if #(
   parameter int MASTERCOUNT = 2,
   parameter int ARCHBITSZ   = 32
);
   localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8);
   localparam int SELBITSZ  = ARCHBITSZ/8;

   logic [2*MASTERCOUNT-1:0]         m_pi1_op_i;
   logic [ADDRBITSZ*MASTERCOUNT-1:0] m_pi1_addr_i;
   logic [ARCHBITSZ*MASTERCOUNT-1:0] m_pi1_data_i;
   logic [ARCHBITSZ-1:0]             m_pi1_data_o;
   logic [SELBITSZ*MASTERCOUNT-1:0]  m_pi1_sel_i;
   logic [MASTERCOUNT-1:0]           m_pi1_rdy_o;
   logic [1:0]                       s_pi1_op_o;
   logic [ADDRBITSZ-1:0]             s_pi1_addr_o;
   logic [ARCHBITSZ-1:0]             s_pi1_data_o;
   logic [ARCHBITSZ-1:0]             s_pi1_data_i;
   logic [SELBITSZ-1:0]              s_pi1_sel_o;
   logic                             s_pi1_rdy_i;

   modport slave (
      input  m_pi1_op_i, m_pi1_addr_i, m_pi1_data_i, m_pi1_sel_i, s_pi1_data_i, s_pi1_rdy_i,
      output m_pi1_data_o, m_pi1_rdy_o, s_pi1_op_o, s_pi1_addr_o, s_pi1_data_o, s_pi1_sel_o
   );

   modport master (
      output m_pi1_op_i, m_pi1_addr_i, m_pi1_data_i, m_pi1_sel_i, s_pi1_data_i, s_pi1_rdy_i,
      input  m_pi1_data_o, m_pi1_rdy_o, s_pi1_op_o, s_pi1_addr_o, s_pi1_data_o, s_pi1_sel_o
   );
endinterface

// File: rtl/pi1_arbiter.sv
// Round-robin share of one pi1 slave among MASTERCOUNT masters; zero-latency forwarding.
// Ownership moves only when the owner is idle and the slave is ready, so responses never misroute.
module pi1_arbiter #(
   parameter int MASTERCOUNT = 2,
   parameter int ARCHBITSZ   = 32
) (
   input logic       clk_i,
   input logic       rst_i,
   pi1_arbiter_if.slave bus
);
   localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8);
   localparam int SELBITSZ  = ARCHBITSZ/8;
   localparam int OWNW      = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1;

   logic [OWNW-1:0]        own;
   logic [OWNW-1:0]        nxt;
   logic                   found;
   logic [1:0]             own_op;
   logic [MASTERCOUNT-1:0] rdy;
   int                     own_idx;

   assign own_idx = int'(own);
   assign own_op  = bus.m_pi1_op_i[2*own_idx +: 2];

   assign bus.s_pi1_op_o   = rst_i ? 2'b00 : own_op;
   assign bus.s_pi1_addr_o = bus.m_pi1_addr_i[ADDRBITSZ*own_idx +: ADDRBITSZ];
   assign bus.s_pi1_data_o = bus.m_pi1_data_i[ARCHBITSZ*own_idx +: ARCHBITSZ];
   assign bus.s_pi1_sel_o  = bus.m_pi1_sel_i[SELBITSZ*own_idx +: SELBITSZ];
   assign bus.m_pi1_data_o = bus.s_pi1_data_i;
   assign bus.m_pi1_rdy_o  = rdy;

   always_comb begin
      rdy = '0;
      for (int k = 0; k < MASTERCOUNT; k++) begin
         rdy[k] = !rst_i && bus.s_pi1_rdy_i && (own_idx == k);
      end
   end

   // Scan farthest-first so the nearest requester after own overwrites the others.
   always_comb begin
      nxt   = own;
      found = 1'b0;
      for (int d = MASTERCOUNT-1; d >= 1; d--) begin
         if (bus.m_pi1_op_i[2*((own_idx + d) % MASTERCOUNT) +: 2] != 2'b00) begin
            nxt   = OWNW'((own_idx + d) % MASTERCOUNT);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         own <= '0;
      end else if (bus.s_pi1_rdy_i && (own_op == 2'b00) && found) begin
         own <= nxt;
      end
   end
endmodule

// File: tb/tb_pi1_arbiter.sv
// Directed and random checks of pi1_arbiter (3 masters) against a cycle-level owner model.
module tb_pi1_arbiter;
   localparam int MC = 3;
   localparam int AW = 30;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pi1_arbiter_if #(.MASTERCOUNT(MC), .ARCHBITSZ(32)) bus ();

   pi1_arbiter #(.MASTERCOUNT(MC), .ARCHBITSZ(32)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   logic [1:0]    op[MC];
   logic [AW-1:0] addr[MC];
   logic [31:0]   wdata[MC];
   logic [3:0]    sel[MC];
   logic          srdy;
   logic [31:0]   sdata;

   int own_m;
   int vectors = 0;
   int miscompares = 0;
   bit rec = 1'b0;
   int grants[$];
   bit acc[MC];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic apply();
      for (int k = 0; k < MC; k++) begin
         bus.m_pi1_op_i[2*k +: 2]     = op[k];
         bus.m_pi1_addr_i[AW*k +: AW] = addr[k];
         bus.m_pi1_data_i[32*k +: 32] = wdata[k];
         bus.m_pi1_sel_i[4*k +: 4]    = sel[k];
      end
      bus.s_pi1_rdy_i  = srdy;
      bus.s_pi1_data_i = sdata;
   endtask

   // Apply inputs, wait to mid-cycle, compare every output against the model.
   task automatic settle();
      logic [MC-1:0] exp_rdy;
      apply();
      @(negedge clk);
      exp_rdy = (!rst && srdy) ? MC'(1 << own_m) : '0;
      chk("s_op", 64'(bus.s_pi1_op_o), 64'(rst ? 2'b00 : op[own_m]));
      chk("m_rdy", 64'(bus.m_pi1_rdy_o), 64'(exp_rdy));
      chk("m_data", 64'(bus.m_pi1_data_o), 64'(sdata));
      if (!rst) begin
         chk("s_addr", 64'(bus.s_pi1_addr_o), 64'(addr[own_m]));
         chk("s_data", 64'(bus.s_pi1_data_o), 64'(wdata[own_m]));
         chk("s_sel", 64'(bus.s_pi1_sel_o), 64'(sel[own_m]));
      end
      for (int k = 0; k < MC; k++) acc[k] = !rst && srdy && (own_m == k) && (op[k] != 2'b00);
      if (rec && bus.s_pi1_op_o != 2'b00 && bus.s_pi1_rdy_i) begin
         for (int k = 0; k < MC; k++) if (bus.m_pi1_rdy_o[k]) grants.push_back(k);
      end
   endtask

   // Clock edge: advance the owner model using the arbitration rules.
   task automatic edge_();
      @(posedge clk);
      if (rst) own_m = 0;
      else if (srdy && op[own_m] == 2'b00) begin
         for (int d = 1; d < MC; d++) begin
            if (op[(own_m + d) % MC] != 2'b00) begin
               own_m = (own_m + d) % MC;
               break;
            end
         end
      end
      #1;
   endtask

   task automatic tick();
      settle();
      edge_();
   endtask

   task automatic idle_all();
      for (int k = 0; k < MC; k++) begin
         op[k] = 2'b00; addr[k] = AW'(k * 16); wdata[k] = 32'h1000 + k; sel[k] = 4'hF;
      end
   endtask

   task automatic reset_pulse();
      idle_all();
      rst = 1'b1; srdy = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      own_m = 0;
      sdata = 32'h0;
      srdy  = 1'b1;
      rst   = 1'b1;
      idle_all();
      // Reset with everyone requesting
      for (int k = 0; k < MC; k++) op[k] = 2'b10;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("rst_op", 64'(bus.s_pi1_op_o), 64'h0);
         chk("rst_rdy", 64'(bus.m_pi1_rdy_o), 64'h0);
         edge_();
      end
      rst = 1'b0;
      settle();
      chk("rel_rdy", 64'(bus.m_pi1_rdy_o), 64'b001);
      chk("rel_op", 64'(bus.s_pi1_op_o), 64'b10);
      edge_();

      // Single master read
      idle_all();
      op[0] = 2'b10; addr[0] = AW'('h100);
      tick();
      op[0] = 2'b00; sdata = 32'hDEADBEEF;
      settle();
      chk("rd_data", 64'(bus.m_pi1_data_o), 64'hDEADBEEF);
      chk("rd_rdy", 64'(bus.m_pi1_rdy_o), 64'b001);
      edge_();
      tick();

      // Hand-off m0 -> m1
      op[1] = 2'b01; addr[1] = AW'('h40); wdata[1] = 32'h12345678; sel[1] = 4'hF;
      op[0] = 2'b10;
      settle();
      chk("ho_rdy0", 64'(bus.m_pi1_rdy_o), 64'b001);
      edge_();
      op[0] = 2'b00; sdata = 32'h0BADF00D;
      settle();
      chk("ho_resp", 64'(bus.m_pi1_data_o), 64'h0BADF00D);
      chk("ho_resp_rdy", 64'(bus.m_pi1_rdy_o), 64'b001);
      edge_();
      settle();
      chk("ho_op", 64'(bus.s_pi1_op_o), 64'b01);
      chk("ho_addr", 64'(bus.s_pi1_addr_o), 64'h40);
      chk("ho_wdata", 64'(bus.s_pi1_data_o), 64'h12345678);
      chk("ho_rdy1", 64'(bus.m_pi1_rdy_o), 64'b010);
      edge_();

      // Round-robin: each master drops to NOOP for one cycle after acceptance
      reset_pulse();
      for (int k = 0; k < MC; k++) begin op[k] = 2'b10; acc[k] = 1'b0; end
      rec = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         for (int k = 0; k < MC; k++) op[k] = acc[k] ? 2'b00 : 2'b10;
      end
      rec = 1'b0;
      begin
         int exp_order[5] = '{0, 1, 2, 0, 1};
         for (int i = 0; i < 5; i++)
            chk($sformatf("rr_grant%0d", i), 64'(i < grants.size() ? grants[i] : -1), 64'(exp_order[i]));
      end

      // Slave stall: owner frozen while m1 waits
      reset_pulse();
      op[0] = 2'b10;
      tick();
      op[0] = 2'b00; op[1] = 2'b01; srdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         chk("st_rdy", 64'(bus.m_pi1_rdy_o), 64'h0);
         chk("st_op", 64'(bus.s_pi1_op_o), 64'h0);
         edge_();
      end
      srdy = 1'b1; sdata = 32'hCAFEF00D;
      settle();
      chk("st_resp_rdy", 64'(bus.m_pi1_rdy_o), 64'b001);
      chk("st_resp", 64'(bus.m_pi1_data_o), 64'hCAFEF00D);
      edge_();
      settle();
      chk("st_sw_rdy", 64'(bus.m_pi1_rdy_o), 64'b010);
      chk("st_sw_op", 64'(bus.s_pi1_op_o), 64'b01);
      edge_();

      // Back-to-back owner keeps the port
      reset_pulse();
      op[1] = 2'b01; addr[1] = AW'('h77);
      for (int i = 0; i < 8; i++) begin
         op[0] = 2'b01; addr[0] = AW'(i + 'h200);
         settle();
         chk("b2b_addr", 64'(bus.s_pi1_addr_o), 64'(i + 'h200));
         chk("b2b_rdy", 64'(bus.m_pi1_rdy_o), 64'b001);
         edge_();
      end
      op[0] = 2'b00;
      settle();
      chk("b2b_last_rdy", 64'(bus.m_pi1_rdy_o), 64'b001);
      edge_();
      settle();
      chk("b2b_m1_rdy", 64'(bus.m_pi1_rdy_o), 64'b010);
      chk("b2b_m1_addr", 64'(bus.s_pi1_addr_o), 64'h77);
      edge_();

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < MC; k++) begin
            op[k]    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            addr[k]  = AW'($urandom);
            wdata[k] = $urandom;
            sel[k]   = 4'($urandom);
         end
         srdy  = ($urandom_range(0, 3) != 0);
         sdata = $urandom;
         rst   = ($urandom_range(0, 63) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pi1_arbiter.md
Name: pi1_arbiter

Overview:
Round-robin arbiter that shares one pi1 slave port between MASTERCOUNT pi1 masters, for example the dcache and icache in front of the memory controller.
- Ownership is transferred only at a transaction boundary, so every read response is delivered to the master that issued it.
- No outstanding-transaction bookkeeping is needed.
- Pure control plus muxing; no data buffering.

Parameters:
MASTERCOUNT, 2, number of masters (>=2; need not be a power of 2)
ARCHBITSZ, 32, data width (16/32/64/128); localparam ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8)

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  reset, synchronous, active-high
m_pi1_op_i  in  2*MASTERCOUNT  master ops; master k at bits [2k+1:2k]
m_pi1_addr_i  in  ADDRBITSZ*MASTERCOUNT  master word addresses, packed the same way
m_pi1_data_i  in  ARCHBITSZ*MASTERCOUNT  master write data
m_pi1_data_o  out  ARCHBITSZ  read data, broadcast to all masters
m_pi1_sel_i  in  (ARCHBITSZ/8)*MASTERCOUNT  master byte selects
m_pi1_rdy_o  out  MASTERCOUNT  per-master ready
s_pi1_op_o  out  2  slave op
s_pi1_addr_o  out  ADDRBITSZ  slave address
s_pi1_data_o  out  ARCHBITSZ  slave write data
s_pi1_data_i  in  ARCHBITSZ  slave read data
s_pi1_sel_o  out  ARCHBITSZ/8  slave byte select
s_pi1_rdy_i  in  1  slave ready

Behaviour:
- Op encoding: NOOP=00, WR=01, RD=10, RW=11.
- A transfer is accepted in a cycle where op!=NOOP and rdy=1.
- The response for an accepted op is valid on the next cycle with s_pi1_rdy_i=1.
- Single register: owner index `own` (clog2(MASTERCOUNT) bits, minimum 1 bit). Reset value 0.
- Forwarding (combinational):
  - s_pi1_op_o/addr_o/data_o/sel_o = the fields of master `own`.
  - m_pi1_data_o = s_pi1_data_i.
  - m_pi1_rdy_o[k] = s_pi1_rdy_i && (k==own).
  - Every non-owner sees rdy=0 and holds its request.
- While rst_i=1: s_pi1_op_o=NOOP and m_pi1_rdy_o=0 for all masters. addr/data/sel pass through but are don't-care.
- Next-owner search (combinational): nxt = first k in the cyclic order own+1, own+2, ..., own+MASTERCOUNT-1 (mod MASTERCOUNT) with op[k]!=NOOP.
  - Use an explicit modulo wrap, not a power-of-2 wrap, so MASTERCOUNT=3 works.
  - found=0 if no other master is requesting.
- Switch condition, evaluated at the clock edge:
  - Switch when s_pi1_rdy_i=1 && op[own]==NOOP && found → own <= nxt.
  - In that cycle the old owner is idle and has rdy=1, so any pending read response is delivered to it before the hand-off.
- Otherwise own holds. An owner that keeps issuing ops back-to-back keeps the port. Masters must return to NOOP for arbitration to proceed; pi1 masters in this design do so after each request.
- The new owner sees rdy in the cycle after the switch. The cost is one slave idle cycle per hand-off.
- Simultaneous requests from several non-owners: the lowest cyclic distance from own+1 wins, giving rotating priority.
- Slave stalled (rdy=0): own is frozen regardless of requests.
- Reset mid-transaction: own returns to 0. The slave is reset on the same rst_i; lost responses are not recovered.
- MASTERCOUNT=1 is not supported.

Test Plan:
- Reset: rst_i=1 for 2 cycles with all masters requesting → s_pi1_op_o=00 and m_pi1_rdy_o=0. First cycle after release: master 0 forwarded, m_pi1_rdy_o=2'b01 with slave rdy=1.
- Single master read: m0 RD addr 0x100, slave returns 0xDEADBEEF next rdy cycle → m_pi1_data_o=0xDEADBEEF while m_pi1_rdy_o[0]=1; own stays 0.
- Hand-off: m0 RD then NOOP, m1 WR addr 0x40 data 0x12345678 sel 4'hF held throughout → m0 receives its read data. The following cycle s_pi1_op_o=01, addr 0x40, data 0x12345678; m1 rdy=1 and m0 rdy=0.
- Round-robin (MASTERCOUNT=3): all three hold RD, each going NOOP for one cycle after acceptance → grant order 0,1,2,0,1.
- Slave stall: owner m0 issues RD, s_pi1_rdy_i=0 for 5 cycles while m1 requests → own stays 0 and m1 rdy=0. Data goes to m0 when rdy returns; switch to m1 happens only after m0 is NOOP with rdy=1.
- Back-to-back owner: m0 issues WR on 8 consecutive cycles → all 8 forwarded, m1 waits. m1 is granted one cycle after m0's first NOOP.
